// File: rtl/ucore_uart.sv
// Register-mapped 8N1 UART: DATA/STATUS/CTRL registers on the core's uart_* bus,
// TX/RX FIFOs, serial transmitter and oversampling-free centre-sampling receiver.

module ucore_uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

module ucore_uart #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       aresetn,
  input  logic [7:0] uart_rcen,
  output logic       uart_rack,
  output logic [7:0] uart_rdata,
  input  logic [7:0] uart_wcen,
  output logic       uart_wack,
  input  logic [7:0] uart_wdata,
  output logic       uart_interrupt,
  output logic       uart_txd,
  input  logic       uart_rxd
);
  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [7:0] ADDR_DATA   = 8'h01;
  localparam logic [7:0] ADDR_STATUS = 8'h02;
  localparam logic [7:0] ADDR_CTRL   = 8'h03;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------------------------------------------------------- FIFOs
  logic       tx_push, tx_load, tx_empty, tx_full;
  logic [7:0] tx_head;
  logic       rx_push, rx_pop, rx_empty, rx_full;
  logic [7:0] rx_head;
  logic [7:0] rx_shift;

  ucore_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .aresetn   (aresetn),
    .push      (tx_push),
    .push_data (uart_wdata),
    .pop       (tx_load),
    .pop_data  (tx_head),
    .empty     (tx_empty),
    .full      (tx_full)
  );

  ucore_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .aresetn   (aresetn),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (rx_pop),
    .pop_data  (rx_head),
    .empty     (rx_empty),
    .full      (rx_full)
  );

  // ---------------------------------------------------------------- registers
  logic [1:0] ctrl;
  logic       frame_err;
  logic       overrun;
  logic       tx_idle;
  logic       rx_valid;
  tx_state_t  tx_state;
  rx_state_t  rx_state;

  assign tx_idle  = tx_empty && (tx_state == TX_IDLE);
  assign rx_valid = !rx_empty;

  // ---------------------------------------------------------------- read channel
  logic       r_armed;
  logic       r_accept;
  logic [7:0] rd_value;
  logic       status_read;

  assign r_accept    = r_armed && (uart_rcen != '0);
  assign status_read = r_accept && (uart_rcen == ADDR_STATUS);
  assign rx_pop      = r_accept && (uart_rcen == ADDR_DATA);

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    rd_value = '0;
    case (uart_rcen)
      ADDR_DATA:   if (!rx_empty) rd_value = rx_head;
      ADDR_STATUS: rd_value = {3'b000, frame_err, overrun, tx_full, tx_idle, rx_valid};
      ADDR_CTRL:   rd_value = {6'b000000, ctrl};
      default:     rd_value = '0;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_armed    <= 1'b1;
      uart_rack  <= 1'b0;
      uart_rdata <= '0;
    end else if (r_accept) begin
      r_armed    <= 1'b0;
      uart_rack  <= 1'b1;
      uart_rdata <= rd_value;
    end else begin
      uart_rack <= 1'b0;
      if (uart_rcen == '0) r_armed <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- write channel
  logic       w_armed;
  logic       w_pend;
  logic       w_accept;
  logic       w_ready_now;
  logic [7:0] w_addr;

  assign w_accept    = w_armed && (uart_wcen != '0);
  assign w_ready_now = (uart_wcen != ADDR_DATA) || !tx_full;
  // The write takes effect in the ack cycle, using the data presented then.
  assign tx_push     = uart_wack && (w_addr == ADDR_DATA);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      w_armed   <= 1'b1;
      w_pend    <= 1'b0;
      w_addr    <= '0;
      uart_wack <= 1'b0;
    end else if (w_accept) begin
      w_armed   <= 1'b0;
      w_addr    <= uart_wcen;
      uart_wack <= w_ready_now;
      w_pend    <= !w_ready_now;
    end else if (w_pend) begin
      // Only a DATA write can stall; TX only drains, so a free slot stays free.
      uart_wack <= !tx_full;
      w_pend    <= tx_full;
    end else begin
      uart_wack <= 1'b0;
      if (uart_wcen == '0) w_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ctrl <= '0;
    end else if (uart_wack && (w_addr == ADDR_CTRL)) begin
      ctrl <= uart_wdata[1:0];
    end
  end

  // ---------------------------------------------------------------- transmitter
  logic [TW-1:0] tx_timer;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;

  assign tx_load = !tx_empty &&
                   ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && (tx_timer == '0)));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      tx_state <= TX_IDLE;
      tx_timer <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      uart_txd <= 1'b1;
    end else if (tx_load) begin
      tx_state <= TX_START;
      tx_shift <= tx_head;
      tx_timer <= BIT_LAST;
      uart_txd <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: uart_txd <= 1'b1;
        TX_START: begin
          if (tx_timer == '0) begin
            tx_state <= TX_DATA;
            tx_timer <= BIT_LAST;
            tx_idx   <= '0;
            uart_txd <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
          end else begin
            tx_timer <= tx_timer - 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_timer == '0) begin
            tx_timer <= BIT_LAST;
            if (tx_idx == 3'd7) begin
              tx_state <= TX_STOP;
              uart_txd <= 1'b1;
            end else begin
              tx_idx   <= tx_idx + 3'd1;
              uart_txd <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_timer <= tx_timer - 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_timer == '0) tx_state <= TX_IDLE;
          else                tx_timer <= tx_timer - 1'b1;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- receiver
  logic          rxd_meta, rxd_sync, rxd_prev;
  logic          rx_fall;
  logic [TW-1:0] rx_timer;
  logic [2:0]    rx_idx;
  logic          rx_stop_tick;
  logic          frame_set;
  logic          overrun_set;

  assign rx_fall      = rxd_prev && !rxd_sync;
  assign rx_stop_tick = (rx_state == RX_STOP) && (rx_timer == '0);
  assign rx_push      = rx_stop_tick && rxd_sync;
  assign frame_set    = rx_stop_tick && !rxd_sync;
  assign overrun_set  = rx_push && rx_full && !rx_pop;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rx_state <= RX_IDLE;
      rx_timer <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state <= RX_START;
            rx_timer <= HALF_LAST;
          end
        end
        RX_START: begin
          if (rx_timer == '0) begin
            // A start bit that is high again at its centre was a glitch.
            rx_state <= rxd_sync ? RX_IDLE : RX_DATA;
            rx_timer <= BIT_LAST;
            rx_idx   <= '0;
          end else begin
            rx_timer <= rx_timer - 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_timer == '0) begin
            rx_shift <= {rxd_sync, rx_shift[7:1]};
            rx_timer <= BIT_LAST;
            if (rx_idx == 3'd7) rx_state <= RX_STOP;
            else                rx_idx   <= rx_idx + 3'd1;
          end else begin
            rx_timer <= rx_timer - 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_timer == '0) rx_state <= RX_IDLE;
          else                rx_timer <= rx_timer - 1'b1;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Sticky error flags: a new event in the clearing cycle wins over the clear.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_set)        frame_err <= 1'b1;
      else if (status_read) frame_err <= 1'b0;
      if (overrun_set)      overrun   <= 1'b1;
      else if (status_read) overrun   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) uart_interrupt <= 1'b0;
    else          uart_interrupt <= (ctrl[0] && rx_valid) || (ctrl[1] && tx_idle);
  end
endmodule

// File: tb/tb_ucore_uart.sv
// Scoreboard bench for ucore_uart: bus/serial stimulus pushes expectations,
// independent monitors decode rack data and the txd line and compare.

module tb_ucore_uart;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       aresetn = 1'b0;
  logic [7:0] uart_rcen = '0;
  logic [7:0] uart_wcen = '0;
  logic [7:0] uart_wdata = '0;
  logic       uart_rxd = 1'b1;
  logic       uart_rack, uart_wack, uart_interrupt, uart_txd;
  logic [7:0] uart_rdata;

  always #5 clk = ~clk;

  ucore_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .uart_rcen      (uart_rcen),
    .uart_rack      (uart_rack),
    .uart_rdata     (uart_rdata),
    .uart_wcen      (uart_wcen),
    .uart_wack      (uart_wack),
    .uart_wdata     (uart_wdata),
    .uart_interrupt (uart_interrupt),
    .uart_txd       (uart_txd),
    .uart_rxd       (uart_rxd)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: what the register map should show, from the core's viewpoint.
  typedef struct {
    logic [7:0] addr;
    logic [7:0] val;
  } rd_exp_t;

  logic [7:0] rx_model[$];
  logic [7:0] tx_exp[$];
  rd_exp_t    rd_exp[$];
  int         tx_starts[$];
  logic [1:0] ctrl_m = '0;
  bit         ferr_m = 1'b0;
  bit         ovr_m  = 1'b0;
  int         cyc = 0;
  int         rack_cnt = 0;
  bit         tx_busy = 1'b0;

  always @(posedge clk) cyc++;

  // Read monitor
  rd_exp_t rd_e;
  always @(negedge clk) begin
    if (aresetn && uart_rack) begin
      rack_cnt++;
      if (rd_exp.size() == 0) begin
        check("unexpected rack", 1, 0);
      end else begin
        rd_e = rd_exp.pop_front();
        check($sformatf("read addr 0x%02h", rd_e.addr), uart_rdata, rd_e.val);
      end
    end
  end

  // TX line monitor: every bit must be held exactly CPB cycles.
  logic       txd_prev = 1'b1;
  logic [9:0] tx_samp;
  bit         tx_stable;
  logic [7:0] tx_want;
  always begin
    @(negedge clk);
    if (aresetn && txd_prev && !uart_txd) begin
      tx_busy   = 1'b1;
      tx_stable = 1'b1;
      tx_starts.push_back(cyc);
      for (int b = 0; b < 10; b++) begin
        for (int k = 0; k < CPB; k++) begin
          if (b != 0 || k != 0) @(negedge clk);
          if (k == 0) tx_samp[b] = uart_txd;
          else if (uart_txd !== tx_samp[b]) tx_stable = 1'b0;
        end
      end
      check("tx frame {stable,start,stop}", {tx_stable, tx_samp[0], tx_samp[9]}, 3'b101);
      if (tx_exp.size() == 0) begin
        check("tx unexpected frame", 1, 0);
      end else begin
        tx_want = tx_exp.pop_front();
        check("tx byte", tx_samp[8:1], tx_want);
      end
      tx_busy = 1'b0;
    end
    txd_prev = uart_txd;
  end

  task automatic wait_tx_drain();
    int n = 0;
    while ((tx_exp.size() != 0 || tx_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("tx drain timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    logic [7:0] v;
    v = '0;
    case (a)
      8'h01: if (rx_model.size() > 0) v = rx_model.pop_front();
      8'h02: begin
        // Status is only read with TX drained: tx_full=0, tx_idle=1.
        v = {3'b000, ferr_m, ovr_m, 1'b0, 1'b1, rx_model.size() > 0};
        ferr_m = 1'b0;
        ovr_m  = 1'b0;
      end
      8'h03: v = {6'b000000, ctrl_m};
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic bus_read(input logic [7:0] a, input int hold, output int lat);
    rd_exp_t e;
    if (a == 8'h02) wait_tx_drain();
    e.addr = a;
    e.val  = model_read(a);
    rd_exp.push_back(e);
    @(negedge clk);
    uart_rcen = a;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!uart_rack && lat < 10);
    if (!uart_rack) check("rack timeout", 0, 1);
    repeat (hold) @(negedge clk);
    uart_rcen = '0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d, output int lat);
    @(negedge clk);
    uart_wcen  = a;
    uart_wdata = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!uart_wack && lat < 500);
    if (!uart_wack) check("wack timeout", 0, 1);
    uart_wcen = '0;
    if (a == 8'h01) tx_exp.push_back(d);
    if (a == 8'h03) ctrl_m = d[1:0];
  endtask

  task automatic drive_frame(input logic [7:0] b, input bit stop_ok);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_rxd = f[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (6) @(negedge clk);
    if (!stop_ok)                    ferr_m = 1'b1;
    else if (rx_model.size() == DEPTH) ovr_m = 1'b1;
    else                             rx_model.push_back(b);
  endtask

  task automatic check_irq(input string name);
    wait_tx_drain();
    repeat (2) @(negedge clk);
    check(name, uart_interrupt, (ctrl_m[0] && rx_model.size() > 0) || ctrl_m[1]);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, base, stalls, op;
    logic [7:0] b;

    repeat (3) @(negedge clk);
    check("reset txd", uart_txd, 1);
    check("reset rack", uart_rack, 0);
    check("reset wack", uart_wack, 0);
    check("reset irq", uart_interrupt, 0);
    check("reset rdata", uart_rdata, 0);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);

    bus_read(8'h02, 0, lat);
    check("read latency", lat, 1);

    bus_write(8'h01, 8'hA5, lat);
    check("write latency", lat, 1);
    wait_tx_drain();

    // Burst beyond FIFO depth: must stall, then stream without idle gaps.
    base = tx_starts.size();
    stalls = 0;
    for (int i = 0; i < 7; i++) begin
      bus_write(8'h01, 8'($urandom), lat);
      if (lat > 1) stalls++;
    end
    wait_tx_drain();
    check("burst wack stalled", stalls > 0, 1);
    check("burst frame count", tx_starts.size() - base, 7);
    for (int i = 1; i < 7; i++)
      check($sformatf("burst gap %0d", i), tx_starts[base + i] - tx_starts[base + i - 1], 10 * CPB);

    // RX with interrupt enabled.
    bus_write(8'h03, 8'h01, lat);
    bus_read(8'h03, 0, lat);
    drive_frame(8'($urandom), 1'b1);
    check_irq("irq rx data");
    bus_read(8'h02, 0, lat);
    bus_read(8'h01, 0, lat);
    check_irq("irq after pop");

    // Overrun: five frames into a four-deep FIFO.
    for (int i = 0; i < 5; i++) drive_frame(8'($urandom), 1'b1);
    bus_read(8'h02, 0, lat);
    bus_read(8'h02, 0, lat);
    for (int i = 0; i < 5; i++) bus_read(8'h01, 0, lat);

    // Framing error, and a request held for 3 cycles gives exactly one ack.
    drive_frame(8'($urandom), 1'b0);
    wait_tx_drain();
    base = rack_cnt;
    bus_read(8'h02, 2, lat);
    repeat (4) @(negedge clk);
    check("held cen single rack", rack_cnt - base, 1);
    bus_read(8'h02, 0, lat);

    // Unmapped addresses and CTRL masking.
    bus_read(8'h07, 0, lat);
    bus_write(8'h55, 8'hFF, lat);
    bus_write(8'h03, 8'hFF, lat);
    bus_read(8'h03, 0, lat);
    check_irq("irq tx idle");
    bus_write(8'h03, 8'h00, lat);

    // Randomised mix.
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: bus_write(8'h01, 8'($urandom), lat);
        1: drive_frame(8'($urandom), $urandom_range(0, 7) != 0);
        2: bus_read(8'h01, 0, lat);
        3: bus_read(8'h02, 0, lat);
        4: bus_write(8'h03, 8'($urandom), lat);
        default: begin
          b = 8'($urandom_range(1, 255));
          bus_read(b, 0, lat);
        end
      endcase
      if (i % 5 == 4) check_irq($sformatf("irq random %0d", i));
    end

    wait_tx_drain();
    repeat (5) @(negedge clk);
    check("reads outstanding", rd_exp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
